// File: rtl/tube_pkg.sv
// Shared types and constants for the Tube host-side controller.
package tube_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic [7:0]  EMPTY_READ_BYTE    = 8'hAA;
  localparam logic [7:0]  UNMAPPED_READ_BYTE = 8'hFF;
  localparam int unsigned CTRL_IRQ_EN        = 0;
  localparam int unsigned CTRL_W             = 6;

endpackage

// File: rtl/tube_ctrl_flags.sv
// Host control flag register (bitwise set/clear on write) and the registered host interrupt.
module tube_ctrl_flags
  import tube_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              set_i,
  input  logic [CTRL_W-1:0] mask_i,
  input  logic              irq_src_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              irq_o
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              irq_q, irq_d;

  // set_i selects between OR-ing in and clearing the masked bits
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_en_i) begin
      ctrl_d = set_i ? (ctrl_q | mask_i) : (ctrl_q & ~mask_i);
    end
    irq_d = ctrl_q[CTRL_IRQ_EN] & irq_src_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= irq_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/tube_host_ctrl.sv
// Tube host-side register controller: decodes host accesses into per-channel FIFO pops/pushes.
// Define OVR_DEBUG_EN to build the sticky overrun register and its status/readback visibility.
module tube_host_ctrl
  import tube_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = 3
) (
  input  logic             h_phi2,
  input  logic             h_rst,
  input  logic             h_cs,
  input  logic [AW-1:0]    h_addr,
  input  logic             h_rdnw,
  input  logic [7:0]       h_din,
  output logic [7:0]       h_dout,
  output logic             h_irq,
  input  logic [NCH-1:0]   ch_avail,
  input  logic [NCH*8-1:0] ch_rdata,
  output logic [NCH-1:0]   ch_rd,
  input  logic [NCH-1:0]   ch_full,
  output logic [NCH-1:0]   ch_wr,
  output logic [7:0]       ch_wdata
);

  localparam int unsigned NW = (AW > 1) ? AW - 1 : 1;
`ifdef OVR_DEBUG_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [7:0]        dout_q, dout_d, wdata_q, wdata_d;
  logic [NCH-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [NCH-1:0]    ovr_set_c, ovr_vis_c, onehot_c;
  logic [CTRL_W-1:0] ctrl;
  logic [NW-1:0]     ch_idx_c;
  logic [7:0]        sel_rdata_c;
  logic              sel_avail_c, sel_full_c, sel_ovr_c;
  logic              start_c, in_range_c, dbg_addr_c, ctrl_we_c;

  assign ch_idx_c   = NW'(h_addr >> 1);
  assign in_range_c = 32'(ch_idx_c) < NCH;
  assign dbg_addr_c = 32'(h_addr) == 2 * NCH;
  assign start_c    = (state_q == IDLE) && h_cs;

  // Per-channel view of the addressed channel
  always_comb begin
    sel_avail_c = 1'b0;
    sel_full_c  = 1'b0;
    sel_ovr_c   = 1'b0;
    sel_rdata_c = '0;
    onehot_c    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (32'(ch_idx_c) == i) begin
        sel_avail_c = ch_avail[i];
        sel_full_c  = ch_full[i];
        sel_ovr_c   = ovr_vis_c[i];
        sel_rdata_c = ch_rdata[8*i +: 8];
        onehot_c[i] = 1'b1;
      end
    end
  end

  // All access decisions are taken in the start cycle only
  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    wdata_d   = wdata_q;
    rd_d      = '0;
    wr_d      = '0;
    ovr_set_c = '0;
    ctrl_we_c = 1'b0;
    if (state_q == ACCESS && !h_cs) begin
      state_d = IDLE;
    end
    if (start_c) begin
      state_d = ACCESS;
      if (h_rdnw) begin
        if (!in_range_c) begin
          dout_d = (DBG_EN && dbg_addr_c) ? 8'(ovr_vis_c) : UNMAPPED_READ_BYTE;
        end else if (!h_addr[0]) begin
          dout_d = {sel_avail_c, ~sel_full_c & ~sel_ovr_c, ctrl};
        end else if (sel_avail_c) begin
          dout_d = sel_rdata_c;
          rd_d   = onehot_c;
        end else begin
          dout_d    = EMPTY_READ_BYTE;
          ovr_set_c = onehot_c;
        end
      end else if (in_range_c) begin
        if (h_addr[0]) begin
          if (!sel_full_c) begin
            wdata_d = h_din;
            wr_d    = onehot_c;
          end else begin
            ovr_set_c = onehot_c;
          end
        end else if (h_addr == '0) begin
          ctrl_we_c = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge h_phi2) begin
    if (h_rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

`ifdef OVR_DEBUG_EN
  logic [NCH-1:0] ovr_q;

  // Sticky overrun flags, cleared only by reset
  always_ff @(posedge h_phi2) begin
    if (h_rst) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_q | ovr_set_c;
    end
  end

  assign ovr_vis_c = ovr_q;
`else
  logic unused_ovr_set;

  assign unused_ovr_set = ^ovr_set_c;
  assign ovr_vis_c      = '0;
`endif

  tube_ctrl_flags u_flags (
    .clk_i     (h_phi2),
    .rst_i     (h_rst),
    .wr_en_i   (ctrl_we_c),
    .set_i     (h_din[7]),
    .mask_i    (h_din[5:0]),
    .irq_src_i (ch_avail[NCH-1]),
    .ctrl_o    (ctrl),
    .irq_o     (h_irq)
  );

  assign h_dout   = dout_q;
  assign ch_wdata = wdata_q;
  assign ch_rd    = rd_q;
  assign ch_wr    = wr_q;

endmodule

// File: tb/tb_tube_host_ctrl.sv
// Bench for tube_host_ctrl: directed steps plus randomized accesses against a behavioural model.
// Honours OVR_DEBUG_EN when compiled with the same define as the RTL.
module tb_tube_host_ctrl;

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 4;
`ifdef OVR_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic             h_phi2 = 1'b0;
  logic             h_rst, h_cs, h_rdnw, h_irq;
  logic [AW-1:0]    h_addr;
  logic [7:0]       h_din, h_dout, ch_wdata;
  logic [NCH-1:0]   ch_avail, ch_rd, ch_full, ch_wr;
  logic [NCH*8-1:0] ch_rdata;

  int vectors = 0;
  int errs    = 0;

  // Behavioural model state
  logic [5:0]     ctrl_m;
  logic [NCH-1:0] ovr_m;
  logic [7:0]     dout_m, wdata_m;

  always #5 h_phi2 = ~h_phi2;

  tube_host_ctrl #(.NCH(NCH), .AW(AW)) dut (
    .h_phi2   (h_phi2),
    .h_rst    (h_rst),
    .h_cs     (h_cs),
    .h_addr   (h_addr),
    .h_rdnw   (h_rdnw),
    .h_din    (h_din),
    .h_dout   (h_dout),
    .h_irq    (h_irq),
    .ch_avail (ch_avail),
    .ch_rdata (ch_rdata),
    .ch_rd    (ch_rd),
    .ch_full  (ch_full),
    .ch_wr    (ch_wr),
    .ch_wdata (ch_wdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ctrl_m  = '0;
    ovr_m   = '0;
    dout_m  = '0;
    wdata_m = '0;
  endtask

  // One host access: h_cs high for 'hold' cycles then one low cycle
  task automatic access(input logic [AW-1:0] a, input logic rdnw, input logic [7:0] d,
                        input int hold, input bit jitter);
    logic [1:0]     ni;
    logic [NCH-1:0] rd_e, wr_e;
    logic [5:0]     ctrl_old;
    bit             mapped;
    ni       = a[2:1];
    mapped   = (a < AW'(2 * NCH));
    rd_e     = '0;
    wr_e     = '0;
    ctrl_old = ctrl_m;
    @(negedge h_phi2);
    h_cs   = 1'b1;
    h_addr = a;
    h_rdnw = rdnw;
    h_din  = d;
    if (rdnw) begin
      if (!mapped) begin
        dout_m = (DBG && a == AW'(2 * NCH)) ? 8'(ovr_m) : 8'hFF;
      end else if (!a[0]) begin
        dout_m = {ch_avail[ni], ~ch_full[ni] & ~(DBG & ovr_m[ni]), ctrl_m};
      end else if (ch_avail[ni]) begin
        dout_m = ch_rdata[8*ni +: 8];
        rd_e   = 4'b0001 << ni;
      end else begin
        dout_m    = 8'hAA;
        ovr_m[ni] = 1'b1;
      end
    end else if (a == '0) begin
      ctrl_m = d[7] ? (ctrl_m | d[5:0]) : (ctrl_m & ~d[5:0]);
    end else if (mapped && a[0]) begin
      if (!ch_full[ni]) begin
        wdata_m = d;
        wr_e    = 4'b0001 << ni;
      end else begin
        ovr_m[ni] = 1'b1;
      end
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge h_phi2);
      if (c == 0) begin
        check("rd_strobe", 32'(ch_rd), 32'(rd_e));
        check("wr_strobe", 32'(ch_wr), 32'(wr_e));
        check("irq_k1", 32'(h_irq), 32'(ctrl_old[0] & ch_avail[NCH-1]));
        if (jitter) begin
          ch_avail = 4'($urandom);
          ch_full  = 4'($urandom);
          ch_rdata = $urandom;
        end
      end else begin
        check("rd_single", 32'(ch_rd), 0);
        check("wr_single", 32'(ch_wr), 0);
        check("irq_hold", 32'(h_irq), 32'(ctrl_m[0] & ch_avail[NCH-1]));
      end
      check("dout", 32'(h_dout), 32'(dout_m));
      check("wdata", 32'(ch_wdata), 32'(wdata_m));
    end
    h_cs = 1'b0;
    @(negedge h_phi2);
    check("rd_idle", 32'(ch_rd), 0);
    check("wr_idle", 32'(ch_wr), 0);
    check("irq_idle", 32'(h_irq), 32'(ctrl_m[0] & ch_avail[NCH-1]));
  endtask

  initial begin
    h_rst    = 1'b1;
    h_cs     = 1'b0;
    h_addr   = '0;
    h_rdnw   = 1'b1;
    h_din    = '0;
    ch_avail = '0;
    ch_full  = '0;
    ch_rdata = '0;
    model_reset();
    repeat (3) @(negedge h_phi2);
    check("rst_dout", 32'(h_dout), 0);
    check("rst_rd", 32'(ch_rd), 0);
    check("rst_wr", 32'(ch_wr), 0);
    check("rst_wdata", 32'(ch_wdata), 0);
    check("rst_irq", 32'(h_irq), 0);
    h_rst = 1'b0;

    // Status read after reset
    access(4'd0, 1'b1, 8'h00, 2, 1'b0);
    check("status0", 32'(h_dout), 32'h40);

    // Pop from channel 1 with a long access; head byte changes mid-access
    ch_avail = 4'b0010;
    ch_rdata = 32'h0000_5C00;
    access(4'd3, 1'b1, 8'h00, 4, 1'b1);
    check("pop_byte", 32'(h_dout), 32'h5C);

    // Empty read, then overrun readback / unmapped address
    ch_avail = 4'b0000;
    access(4'd3, 1'b1, 8'h00, 2, 1'b0);
    check("empty_read", 32'(h_dout), 32'hAA);
    access(4'd8, 1'b1, 8'h00, 2, 1'b0);
    check("ovr_or_unmapped", 32'(h_dout), DBG ? 32'h02 : 32'hFF);

    // Interrupt enable set then cleared
    ch_avail = 4'b1000;
    access(4'd0, 1'b0, 8'h81, 2, 1'b0);
    check("irq_on", 32'(h_irq), 1);
    access(4'd0, 1'b0, 8'h01, 2, 1'b0);
    check("irq_off", 32'(h_irq), 0);

    // Push to channel 2, then dropped push when full
    ch_full = 4'b0000;
    access(4'd5, 1'b0, 8'h3E, 2, 1'b0);
    ch_full = 4'b0100;
    access(4'd5, 1'b0, 8'h77, 2, 1'b0);
    check("push_kept", 32'(ch_wdata), 32'h3E);

    // Randomized accesses
    for (int i = 0; i < 80; i++) begin
      ch_avail = 4'($urandom);
      ch_full  = 4'($urandom);
      ch_rdata = $urandom;
      access(4'($urandom_range(0, 15)), 1'($urandom), 8'($urandom),
             int'($urandom_range(2, 4)), 1'b1);
    end

    // Reset during an access start, then a fresh start once reset releases
    access(4'd0, 1'b0, 8'hBF, 2, 1'b0);
    @(negedge h_phi2);
    ch_avail = 4'b0010;
    ch_full  = 4'b0000;
    ch_rdata = 32'h0000_9100;
    h_cs     = 1'b1;
    h_addr   = 4'd3;
    h_rdnw   = 1'b1;
    h_rst    = 1'b1;
    @(negedge h_phi2);
    model_reset();
    check("rstmid_rd", 32'(ch_rd), 0);
    check("rstmid_dout", 32'(h_dout), 0);
    check("rstmid_irq", 32'(h_irq), 0);
    h_rst = 1'b0;
    @(negedge h_phi2);
    check("fresh_rd", 32'(ch_rd), 32'b0010);
    check("fresh_dout", 32'(h_dout), 32'h91);
    dout_m = 8'h91;
    @(negedge h_phi2);
    check("fresh_single", 32'(ch_rd), 0);
    h_cs = 1'b0;
    @(negedge h_phi2);
    access(4'd0, 1'b1, 8'h00, 2, 1'b0);
    check("ctrl_cleared", 32'(h_dout), 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
